// File: rtl/radio_pkt_sched.sv
// Packet-granular scheduler sharing one AXI-stream uplink among four producers.
// Grants are held from a packet's first beat through its tlast beat.

module radio_pkt_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;

    // Clear takes precedence over a coincident packet completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (inc_i) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
endmodule

module radio_pkt_sched #(
    parameter int         WIDTH   = 64,
    parameter logic [7:0] SR_BASE = 8'd8,
    parameter int         CNT_W   = 16
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [4*WIDTH-1:0]   i_tdata,
    input  logic [3:0]           i_tlast,
    input  logic [3:0]           i_tvalid,
    output logic [3:0]           i_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [1:0]           cur_port,
    output logic                 busy,
    output logic [4*CNT_W-1:0]   pkt_cnt
);
    localparam int NP = 4;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t     state_q;
    logic [1:0] cur_port_q, cur_port_d;
    logic       busy_q;
    logic [3:0] mask_q;
    logic       mode_q;

    logic [3:0] req;
    logic [1:0] rr_win, fp_win;
    logic       in_grant, beat_last, ctl_wr, clr_wr;
    logic       unused_set;

    assign in_grant   = (state_q == S_GRANT);
    assign ctl_wr     = set_stb && (set_addr == SR_BASE);
    assign clr_wr     = set_stb && (set_addr == 8'(SR_BASE + 8'd1));
    assign unused_set = ^{set_data[31:9], set_data[7:4]};

    // Descending scan so the nearest candidate after cur_port wins.
    always_comb begin
        req    = i_tvalid & mask_q;
        rr_win = cur_port_q;
        fp_win = 2'd0;
        for (int k = NP; k >= 1; k--) begin
            if (req[2'(cur_port_q + 2'(k))]) rr_win = 2'(cur_port_q + 2'(k));
        end
        for (int k = NP - 1; k >= 0; k--) begin
            if (req[k]) fp_win = 2'(k);
        end
        cur_port_d = mode_q ? fp_win : rr_win;
    end

    always_comb begin
        o_tdata  = '0;
        o_tlast  = 1'b0;
        o_tvalid = 1'b0;
        i_tready = '0;
        if (in_grant) begin
            o_tdata              = i_tdata[int'(cur_port_q)*WIDTH +: WIDTH];
            o_tlast              = i_tlast[cur_port_q];
            o_tvalid             = i_tvalid[cur_port_q];
            i_tready[cur_port_q] = o_tready;
        end
    end

    assign beat_last = o_tvalid & o_tready & o_tlast;

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q    <= S_IDLE;
            cur_port_q <= 2'd3;
            busy_q     <= 1'b0;
            mask_q     <= 4'hF;
            mode_q     <= 1'b0;
        end else begin
            if (ctl_wr) begin
                mask_q <= set_data[3:0];
                mode_q <= set_data[8];
            end
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        cur_port_q <= cur_port_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (beat_last) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cur_port = cur_port_q;
    assign busy     = busy_q;

    for (genvar n = 0; n < NP; n++) begin : g_cnt
        radio_pkt_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (bus_clk),
            .rst_i (bus_rst),
            .inc_i (beat_last && (cur_port_q == 2'(n))),
            .clr_i (clr_wr),
            .cnt_o (pkt_cnt[n*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_radio_pkt_sched.sv
// Randomized and directed bench for radio_pkt_sched against a transaction-level
// arbitration model; counters narrowed to 8 bits so wraparound is reachable.

module tb_radio_pkt_sched;
    localparam int         W  = 64;
    localparam int         CW = 8;
    localparam logic [7:0] SB = 8'd8;

    logic            bus_clk = 1'b0;
    logic            bus_rst;
    logic            set_stb;
    logic [7:0]      set_addr;
    logic [31:0]     set_data;
    logic [4*W-1:0]  i_tdata;
    logic [3:0]      i_tlast, i_tvalid, i_tready;
    logic [W-1:0]    o_tdata;
    logic            o_tlast, o_tvalid, o_tready;
    logic [1:0]      cur_port;
    logic            busy;
    logic [4*CW-1:0] pkt_cnt;

    radio_pkt_sched #(.WIDTH(W), .SR_BASE(SB), .CNT_W(CW)) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .cur_port(cur_port), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    int total = 0, bad = 0;
    int rem[4], seq[4], vp[4], fl[4], pk_left[4], hs_cnt[4];
    int trp, tr_mode, ti, obeats;
    bit rnd_set, clr_on_tlast, clr_hit, prev_busy;
    int glog[$];
    logic [63:0] dq[$];

    // Reference model: which port holds the uplink, settings, packet counts.
    bit m_busy; int m_port; logic [3:0] m_mask; bit m_mode; int m_cnt[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*CW-1:0] m_cnt_vec();
        logic [4*CW-1:0] v;
        for (int n = 0; n < 4; n++) v[n*CW +: CW] = CW'(m_cnt[n]);
        return v;
    endfunction

    task automatic fill(input int n);
        i_tvalid[n]         = 1'b1;
        i_tdata[n*W +: W]   = {8'(n), 24'(seq[n]), 32'($urandom())};
        i_tlast[n]          = (rem[n] == 1);
    endtask

    // Producers: hold a beat until accepted, packets of fl[n] beats (or random 1..5).
    task automatic src_drive(input logic [3:0] hs);
        for (int n = 0; n < 4; n++) begin
            if (hs[n]) begin rem[n]--; seq[n]++; end
            if (!(i_tvalid[n] && !hs[n])) begin
                i_tvalid[n] = 1'b0;
                if (rem[n] == 0) begin
                    if (pk_left[n] != 0 && int'($urandom_range(0, 99)) < vp[n]) begin
                        rem[n] = (fl[n] > 0) ? fl[n] : int'($urandom_range(1, 5));
                        if (pk_left[n] > 0) pk_left[n]--;
                        fill(n);
                    end
                end else if (int'($urandom_range(0, 99)) < vp[n]) begin
                    fill(n);
                end
            end
        end
        if (tr_mode == 1) o_tready = (ti % 4 == 0) || (ti % 4 == 3);
        else              o_tready = int'($urandom_range(0, 99)) < trp;
        ti++;
    endtask

    task automatic rand_write();
        int r;
        r = int'($urandom_range(0, 9));
        set_stb = 1'b1;
        if (r < 5) begin
            set_addr = SB;
            set_data = {23'd0, 1'($urandom()), 4'd0, 4'($urandom())};
        end else if (r < 7) begin
            set_addr = SB + 8'd1;
            set_data = $urandom();
        end else begin
            set_addr = (r == 7) ? SB - 8'd1 : SB + 8'd2;
            set_data = $urandom();
        end
    endtask

    task automatic do_reset();
        bus_rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
        i_tvalid = '0; i_tlast = '0; i_tdata = '0; o_tready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            rem[n] = 0; seq[n] = 0; hs_cnt[n] = 0; vp[n] = 0; fl[n] = 0; pk_left[n] = -1;
            m_cnt[n] = 0;
        end
        m_busy = 0; m_port = 3; m_mask = 4'hF; m_mode = 0;
        trp = 100; tr_mode = 0; ti = 0; obeats = 0; rnd_set = 0; prev_busy = 0;
        glog.delete(); dq.delete();
        @(negedge bus_clk);
        chk("rst_busy", busy, 0);
        chk("rst_port", cur_port, 3);
        chk("rst_rdy", i_tready, 0);
        chk("rst_vld", o_tvalid, 0);
        chk("rst_last", o_tlast, 0);
        chk("rst_data", o_tdata, 0);
        chk("rst_cnt", pkt_cnt, 0);
        @(posedge bus_clk); #1;
        bus_rst = 1'b0;
    endtask

    task automatic cycle();
        logic [3:0] hs, req, er;
        int win, p;
        bit found;
        @(negedge bus_clk);
        if (clr_on_tlast && o_tvalid && o_tready && o_tlast && cur_port == 2'd2) begin
            set_stb = 1'b1; set_addr = SB + 8'd1; set_data = '0;
            clr_on_tlast = 0; clr_hit = 1;
        end
        er = (m_busy && o_tready) ? (4'b1 << m_port) : 4'b0;
        chk("busy", busy, m_busy);
        chk("cur_port", cur_port, 64'(m_port));
        chk("i_tready", i_tready, er);
        chk("o_tvalid", o_tvalid, m_busy && i_tvalid[m_port]);
        chk("o_tlast", o_tlast, m_busy && i_tlast[m_port]);
        chk("o_tdata", o_tdata, m_busy ? i_tdata[m_port*W +: W] : 64'd0);
        chk("pkt_cnt", pkt_cnt, m_cnt_vec());
        hs = i_tvalid & i_tready;
        for (int n = 0; n < 4; n++) hs_cnt[n] += int'(hs[n]);
        if (o_tvalid && o_tready) begin obeats++; dq.push_back(o_tdata); end
        if (busy && !prev_busy) glog.push_back(int'(cur_port));
        prev_busy = busy;
        if (!m_busy) begin
            req = i_tvalid & m_mask; found = 0; win = 0;
            for (int k = 0; k < 4; k++) begin
                p = m_mode ? k : (m_port + k + 1) % 4;
                if (!found && req[p]) begin win = p; found = 1; end
            end
            if (found) begin m_port = win; m_busy = 1; end
        end else if (i_tvalid[m_port] && o_tready && i_tlast[m_port]) begin
            m_cnt[m_port] = (m_cnt[m_port] + 1) % (1 << CW);
            m_busy = 0;
        end
        if (set_stb && set_addr == SB + 8'd1) for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        if (set_stb && set_addr == SB) begin m_mask = set_data[3:0]; m_mode = set_data[8]; end
        @(posedge bus_clk); #1;
        set_stb = 1'b0;
        if (rnd_set && $urandom_range(0, 99) < 6) rand_write();
        src_drive(hs);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int first, n23, nz;

        // Round-robin between ports 0 and 2, back-to-back 3-beat packets.
        do_reset();
        vp[0] = 100; vp[2] = 100; fl[0] = 3; fl[2] = 3;
        src_drive(4'b0); run(16);
        chk("A_cnt0", pkt_cnt[0 +: CW], 2);
        chk("A_cnt2", pkt_cnt[2*CW +: CW], 2);
        chk("A_ngrant", glog.size(), 4);
        for (int k = 0; k < glog.size(); k++) chk($sformatf("A_grant%0d", k), glog[k], (k % 2) * 2);

        // Fixed priority: port 0 monopolises, then port 1 once port 0 stops.
        do_reset();
        set_stb = 1'b1; set_addr = SB; set_data = 32'h10F;
        for (int n = 0; n < 4; n++) vp[n] = 100;
        src_drive(4'b0); run(40);
        nz = 0;
        foreach (glog[k]) if (glog[k] != 0) nz++;
        chk("B_only0", nz, 0);
        chk("B_others_rdy", hs_cnt[1] + hs_cnt[2] + hs_cnt[3], 0);
        pk_left[0] = 0; glog.delete(); run(40);
        first = -1; n23 = 0;
        foreach (glog[k]) begin
            if (glog[k] != 0 && first < 0) first = glog[k];
            if (glog[k] > 1) n23++;
        end
        chk("B_next", first, 1);
        chk("B_no23", n23, 0);

        // Mask change during port 1's 5-beat packet.
        do_reset();
        vp[1] = 100; fl[1] = 5; pk_left[1] = 1;
        src_drive(4'b0); run(3);
        vp[0] = 100; vp[3] = 100;
        set_stb = 1'b1; set_addr = SB; set_data = 32'h0A;
        glog.delete(); for (int n = 0; n < 4; n++) hs_cnt[n] = 0;
        run(30);
        chk("C_p0_rdy", hs_cnt[0], 0);
        chk("C_p1_rest", hs_cnt[1], 3);
        chk("C_cnt1", pkt_cnt[CW +: CW], 1);
        chk("C_next", (glog.size() > 0) ? glog[0] : -1, 3);

        // Empty mask: nothing is ever granted.
        do_reset();
        set_stb = 1'b1; set_addr = SB; set_data = 32'h0;
        src_drive(4'b0); run(1);
        for (int n = 0; n < 4; n++) vp[n] = 100;
        run(20);
        chk("M0_rdy", hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3], 0);
        chk("M0_busy", busy, 0);

        // Backpressure pattern 1,0,0,1 on a single 4-beat packet from port 3.
        do_reset();
        vp[3] = 100; fl[3] = 4; pk_left[3] = 1; tr_mode = 1;
        src_drive(4'b0); run(20);
        chk("D_beats", obeats, 4);
        chk("D_cnt3", pkt_cnt[3*CW +: CW], 1);
        for (int k = 0; k < dq.size(); k++) begin
            chk($sformatf("D_seq%0d", k), dq[k][55:32], k);
            chk($sformatf("D_src%0d", k), dq[k][63:56], 3);
        end

        // Counter wrap on single-beat packets, then clear coincident with tlast.
        do_reset();
        vp[1] = 100; fl[1] = 1;
        src_drive(4'b0); run(2 * 255);
        chk("E_full", pkt_cnt[CW +: CW], 255);
        run(2);
        chk("E_wrap", pkt_cnt[CW +: CW], 0);
        vp[1] = 0; pk_left[1] = 0;
        vp[2] = 100; fl[2] = 3; pk_left[2] = 1;
        clr_on_tlast = 1; clr_hit = 0;
        for (int i = 0; i < 20 && !clr_hit; i++) cycle();
        chk("E_hit", clr_hit, 1);
        chk("E_clr2", pkt_cnt[2*CW +: CW], 0);
        chk("E_clr1", pkt_cnt[CW +: CW], 0);
        clr_on_tlast = 0;

        // Asynchronous reset in the middle of a port 0 packet.
        do_reset();
        vp[0] = 100; fl[0] = 5;
        src_drive(4'b0); run(3);
        chk("F_pre_vld", o_tvalid, 1);
        #2 bus_rst = 1'b1;
        #1;
        chk("F_rdy", i_tready, 0);
        chk("F_vld", o_tvalid, 0);
        chk("F_busy", busy, 0);
        chk("F_data", o_tdata, 0);
        do_reset();
        vp[1] = 100; vp[2] = 100;
        src_drive(4'b0); run(3);
        chk("F_first", (glog.size() > 0) ? glog[0] : -1, 1);

        // Random traffic, backpressure and settings writes.
        do_reset();
        for (int n = 0; n < 4; n++) vp[n] = int'($urandom_range(30, 90));
        trp = 70; rnd_set = 1;
        src_drive(4'b0); run(2500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
